// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction memory,
// and presents each fetched word to decode over a valid/ready handshake.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_en_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        done_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // One past the last valid byte address, widened so the compare cannot wrap.
  localparam logic [32:0] END_ADDR = 33'(DEPTH) * 33'd4;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic        vld_p1;
  logic        done_q;
  logic        err_q;
  logic        en_q;

  logic        load;
  logic        transfer;
  logic        redirect_bad;
  logic [32:0] pc_next_wide;
  logic        last_word;

  assign transfer     = vld_p1 & instr_ready_i;
  assign load         = (state == FETCH) & (!vld_p1 | instr_ready_i) & !redirect_valid_i;
  assign redirect_bad = (redirect_pc_i[1:0] != 2'b00) || ({1'b0, redirect_pc_i} >= END_ADDR);
  assign pc_next_wide = {1'b0, pc_q} + 33'd4;
  assign last_word    = (pc_next_wide >= END_ADDR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
    end else if (state == ERROR) begin
      vld_p1 <= 1'b0;
    end else if (redirect_valid_i) begin
      // Redirect flushes whatever is presented, even if decode is ready this cycle.
      vld_p1 <= 1'b0;
      if (redirect_bad) begin
        state  <= ERROR;
        err_q  <= 1'b1;
        done_q <= 1'b0;
        en_q   <= 1'b0;
      end else begin
        state  <= FETCH;
        pc_q   <= redirect_pc_i;
        done_q <= 1'b0;
        en_q   <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          en_q  <= 1'b1;
        end
        FETCH: begin
          if (load) begin
            instr_p1 <= imem_instr_i;
            pc_p1    <= pc_q;
            vld_p1   <= 1'b1;
            pc_q     <= pc_next_wide[31:0];
            if (last_word) begin
              state  <= DONE;
              done_q <= 1'b1;
              en_q   <= 1'b0;
            end
          end
        end
        DONE: begin
          if (transfer) vld_p1 <= 1'b0;
        end
        default: begin
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr_o   = pc_q;
  assign imem_en_o     = en_q;
  assign instr_valid_o = vld_p1;
  assign instr_o       = instr_p1;
  assign pc_o          = pc_p1;
  assign done_o        = done_q;
  assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a 16-word behavioural instruction memory.
module tb_instr_fetch_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        done;
  logic        fetch_err;

  logic [31:0] mem [0:DEPTH-1];

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_addr_o      (imem_addr),
    .imem_en_o        (imem_en),
    .imem_instr_i     (imem_instr),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .pc_o             (pc),
    .done_o           (done),
    .fetch_err_o      (fetch_err)
  );

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[5:2]];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    #2;
    vectors++;
    if ({instr_valid, done, fetch_err, imem_en} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got v/d/e/en=%b required 0000", {instr_valid, done, fetch_err, imem_en});
    end
    vectors++;
    if (instr !== 32'h0 || pc !== 32'h0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got instr=%h pc=%h addr=%h required 0/0/0", instr, pc, imem_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_i [0:2];
    exp_i[0] = 32'h00500093; exp_i[1] = 32'h00A00113; exp_i[2] = 32'h002081B3;
    do_reset();
    step();
    vectors++;
    if (instr_valid !== 1'b0 || imem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL t1_cycle1 got valid=%b en=%b required valid=0 en=1", instr_valid, imem_en);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (instr_valid !== 1'b1 || pc !== 32'(i * 4) || instr !== exp_i[i]) begin
        miscompares++;
        $display("FAIL t1_beat%0d got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 i, instr_valid, pc, instr, 32'(i * 4), exp_i[i]);
      end
    end
  endtask

  task automatic test_stall;
    do_reset();
    step();
    step();
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h00A00113 || imem_addr !== 32'h8) begin
        miscompares++;
        $display("FAIL t2_hold%0d got v=%b pc=%h instr=%h addr=%h required 1/4/00a00113/8",
                 i, instr_valid, pc, instr, imem_addr);
      end
    end
    instr_ready = 1'b1;
    step();
    vectors++;
    if (instr_valid !== 1'b1 || pc !== 32'h8 || instr !== 32'h002081B3) begin
      miscompares++;
      $display("FAIL t2_resume got v=%b pc=%h instr=%h required 1/8/002081b3", instr_valid, pc, instr);
    end
    step();
    vectors++;
    if (pc !== 32'hC || instr !== mem[3]) begin
      miscompares++;
      $display("FAIL t2_next got pc=%h instr=%h required c/%h", pc, instr, mem[3]);
    end
  endtask

  task automatic test_redirect;
    do_reset();
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL t3_flush got v=%b addr=%h required v=0 addr=20", instr_valid, imem_addr);
    end
    step();
    vectors++;
    if (instr_valid !== 1'b1 || pc !== 32'h20 || instr !== mem[8]) begin
      miscompares++;
      $display("FAIL t3_target got v=%b pc=%h instr=%h required 1/20/%h", instr_valid, pc, instr, mem[8]);
    end
  endtask

  task automatic test_done;
    int bad;
    do_reset();
    step();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if (instr_valid !== 1'b1 || pc !== 32'(i * 4) || instr !== mem[i]) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL t4_run got %0d bad beats required 0", bad);
    end
    vectors++;
    if (done !== 1'b1 || imem_en !== 1'b0 || pc !== 32'h3C || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_last got done=%b en=%b pc=%h v=%b required 1/0/3c/1", done, imem_en, pc, instr_valid);
    end
    step();
    vectors++;
    if (done !== 1'b1 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_drain got done=%b v=%b required 1/0", done, instr_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if (done !== 1'b0 || imem_en !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL t4_restart got done=%b en=%b v=%b addr=%h required 0/1/0/0", done, imem_en, instr_valid, imem_addr);
    end
    step();
    vectors++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== mem[0]) begin
      miscompares++;
      $display("FAIL t4_refetch got v=%b pc=%h instr=%h required 1/0/%h", instr_valid, pc, instr, mem[0]);
    end
  endtask

  task automatic test_error;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    step();
    vectors++;
    if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_misalign got err=%b v=%b en=%b required 1/0/0", fetch_err, instr_valid, imem_en);
    end
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    vectors++;
    if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL t5_sticky got err=%b v=%b en=%b addr=%h required 1/0/0/4", fetch_err, instr_valid, imem_en, imem_addr);
    end
    // Aligned but one word past the end of memory.
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if (fetch_err !== 1'b1 || imem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_range got err=%b en=%b required 1/0", fetch_err, imem_en);
    end
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    step();
    step();
    step();
    instr_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h0 || imem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_async got v=%b pc=%h instr=%h addr=%h en=%b required 0/0/0/0/0",
               instr_valid, pc, instr, imem_addr, imem_en);
    end
    instr_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    vectors++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h00500093) begin
      miscompares++;
      $display("FAIL t6_restart got v=%b pc=%h instr=%h required 1/0/00500093", instr_valid, pc, instr);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    mem[2] = 32'h002081B3;
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_done();
    test_error();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
